// File: rtl/udma_spim_rx_unpacker.sv
// udma_spim_rx_unpacker: splits 32-bit RX FIFO words into 8/16/32-bit units
// for the uDMA RX channel, counting units per transfer and discarding the
// surplus lanes of the final word.
// Optional build macro SPIM_RX_UNPACK_STATS_EN adds drop_cnt_o, a saturating
// count of lanes discarded at the end of the transfer.
module udma_spim_rx_unpacker #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [1:0]           cfg_datasize_i,
  input  logic                 cfg_msb_first_i,
  input  logic [CNT_WIDTH-1:0] cfg_len_i,
  input  logic                 start_i,
  input  logic                 flush_i,
  input  logic [31:0]          in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [31:0]          out_data_o,
  output logic [1:0]           out_datasize_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 done_o,
`ifdef SPIM_RX_UNPACK_STATS_EN
  output logic [CNT_WIDTH-1:0] drop_cnt_o,
`endif
  output logic                 busy_o
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q, state_d;
  logic [31:0]          buf_q;
  logic                 bv_q;
  logic [1:0]           sz_q;
  logic [1:0]           idx_q;
  logic [CNT_WIDTH-1:0] rem_q;
  logic                 msb_q;
  logic                 done_q;

  logic [1:0] last_idx;
  logic [1:0] lane;
  logic [4:0] shamt;
  logic [31:0] data_sh;
  logic       last_lane;
  logic       out_hs;
  logic       in_hs;
  logic       fin;

  // Lanes per word from the latched unit size; size 11 behaves like a word.
  always_comb begin
    last_idx = 2'd0;
    case (sz_q)
      2'b00:   last_idx = 2'd3;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd0;
    endcase
  end

  assign last_lane = (idx_q == last_idx);
  assign out_hs    = bv_q & out_ready_i;
  assign in_hs     = in_valid_i & in_ready_o;
  // Handshake that consumes the final unit of the transfer.
  assign fin       = out_hs & (rem_q == CNT_WIDTH'(1));

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush wins over everything else.
  always_comb begin
    state_d = state_q;
    if (flush_i) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    if (start_i && cfg_len_i != '0) state_d = RUN;
        RUN:     if (fin) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs: handshakes and the lane mux. A word is refilled in the same
  // cycle its last lane leaves, unless that lane ends the transfer.
  always_comb begin
    busy_o         = (state_q == RUN);
    in_ready_o     = (state_q == RUN) & ~flush_i &
                     (~bv_q | (out_hs & last_lane & (rem_q > CNT_WIDTH'(1))));
    out_valid_o    = bv_q;
    lane           = msb_q ? (last_idx - idx_q) : idx_q;
    shamt          = (sz_q == 2'b00) ? {lane, 3'b000} : {lane[0], 4'b0000};
    data_sh        = buf_q >> shamt;
    out_data_o     = '0;
    out_datasize_o = '0;
    if (bv_q) begin
      out_datasize_o = sz_q;
      case (sz_q)
        2'b00:   out_data_o = {24'b0, data_sh[7:0]};
        2'b01:   out_data_o = {16'b0, data_sh[15:0]};
        default: out_data_o = buf_q;
      endcase
    end
  end

  assign done_o = done_q;

  // Word buffer, lane index, unit counter and done pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q  <= '0;
      bv_q   <= 1'b0;
      sz_q   <= '0;
      idx_q  <= '0;
      rem_q  <= '0;
      msb_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush_i) begin
        bv_q  <= 1'b0;
        idx_q <= '0;
        rem_q <= '0;
      end else if (state_q == IDLE) begin
        if (start_i) begin
          rem_q  <= cfg_len_i;
          msb_q  <= cfg_msb_first_i;
          done_q <= (cfg_len_i == '0);
        end
      end else begin
        if (out_hs) begin
          rem_q <= rem_q - CNT_WIDTH'(1);
          if (fin) begin
            bv_q   <= 1'b0;
            idx_q  <= '0;
            done_q <= 1'b1;
          end else if (!last_lane) begin
            idx_q <= idx_q + 2'd1;
          end else begin
            bv_q <= 1'b0;
          end
        end
        if (in_hs) begin
          buf_q <= in_data_i;
          sz_q  <= cfg_datasize_i;
          idx_q <= '0;
          bv_q  <= 1'b1;
        end
      end
    end
  end

`ifdef SPIM_RX_UNPACK_STATS_EN
  logic [CNT_WIDTH:0] drop_sum;
  assign drop_sum = {1'b0, drop_cnt_o} + (CNT_WIDTH+1)'(last_idx - idx_q);

  // Saturating count of lanes left unsent in the final word.
  always_ff @(posedge clk_i) begin
    if (rst_i) drop_cnt_o <= '0;
    else if (!flush_i && state_q == IDLE && start_i) drop_cnt_o <= '0;
    else if (!flush_i && state_q == RUN && fin)
      drop_cnt_o <= drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
  end
`endif

endmodule

// File: tb/tb_udma_spim_rx_unpacker.sv
// Randomized self-checking bench for udma_spim_rx_unpacker. Expected units
// come from flattening the supplied words into lanes and truncating to len.
module tb_udma_spim_rx_unpacker;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    cfg_datasize;
  logic          cfg_msb_first;
  logic [CW-1:0] cfg_len;
  logic          start, flush;
  logic [31:0]   in_data;
  logic          in_valid, in_ready;
  logic [31:0]   out_data;
  logic [1:0]    out_datasize;
  logic          out_valid, out_ready;
  logic          done, busy;
`ifdef SPIM_RX_UNPACK_STATS_EN
  logic [CW-1:0] drop_cnt;
`endif

  udma_spim_rx_unpacker #(.CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_datasize_i(cfg_datasize), .cfg_msb_first_i(cfg_msb_first),
    .cfg_len_i(cfg_len), .start_i(start), .flush_i(flush),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_data_o(out_data), .out_datasize_o(out_datasize),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .done_o(done),
`ifdef SPIM_RX_UNPACK_STATS_EN
    .drop_cnt_o(drop_cnt),
`endif
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] wq[$];
  logic [1:0]  sq[$];
  logic [31:0] exp_d[$];
  logic [1:0]  exp_s[$];
  int          need, drop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: list every lane of every word in emission order, keep len.
  task automatic build_exp(input int len, input bit msb);
    int total;
    exp_d.delete(); exp_s.delete();
    need = 0; total = 0;
    for (int k = 0; k < wq.size() && total < len; k++) begin
      int n, w;
      n = (sq[k] == 2'd0) ? 4 : (sq[k] == 2'd1) ? 2 : 1;
      w = 32 / n;
      need++;
      for (int j = 0; j < n; j++) begin
        int p;
        logic [31:0] u;
        p = msb ? (n - 1 - j) : j;
        u = (n == 1) ? wq[k] : ((wq[k] >> (p * w)) & ((32'd1 << w) - 32'd1));
        total++;
        if (total <= len) begin
          exp_d.push_back(u);
          exp_s.push_back(sq[k]);
        end
      end
    end
    drop = total - len;
  endtask

  task automatic do_start(input int len, input bit msb);
    @(negedge clk);
    start = 1'b1; cfg_len = CW'(len); cfg_msb_first = msb;
    in_valid = 1'b0; out_ready = 1'b0;
    #1 chk("start_in_ready", in_ready, 0);
    @(negedge clk);
    start = 1'b0;
  endtask

  // One transfer over wq/sq; exp_cyc >= 0 also checks the cycle count.
  task automatic run_xfer(input int len, input bit msb, input int rdy_pct,
                          input int vld_pct, input int exp_cyc);
    int ui, wi, cyc;
    build_exp(len, msb);
    do_start(len, msb);
    ui = 0; wi = 0; cyc = 0;
    while (ui < len && cyc < 2000) begin
      in_valid     = (wi < wq.size()) && ($urandom_range(99) < vld_pct);
      in_data      = (wi < wq.size()) ? wq[wi] : $urandom;
      cfg_datasize = (wi < wq.size()) ? sq[wi] : 2'($urandom);
      out_ready    = ($urandom_range(99) < rdy_pct);
      #1;
      chk("done_early", done, 0);
      chk("busy_run", busy, 1);
      if (out_valid) begin
        chk("unit_data", out_data, exp_d[ui]);
        chk("unit_size", 32'(out_datasize), 32'(exp_s[ui]));
      end
      if (out_valid && out_ready) ui++;
      if (in_valid && in_ready) wi++;
      @(negedge clk);
      cyc++;
    end
    if (ui < len) chk("timeout", 1, 0);
    if (exp_cyc >= 0) chk("cycles", cyc, exp_cyc);
    in_valid  = (wi < wq.size());
    out_ready = 1'b1;
    #1;
    chk("done_pulse", done, 1);
    chk("busy_end", busy, 0);
    chk("ready_end", in_ready, 0);
    chk("valid_end", out_valid, 0);
    chk("words_used", wi, need);
`ifdef SPIM_RX_UNPACK_STATS_EN
    chk("drop_cnt", 32'(drop_cnt), drop);
`endif
    @(negedge clk);
    #1;
    chk("done_once", done, 0);
    chk("ready_idle", in_ready, 0);
    in_valid = 1'b0;
  endtask

  task automatic set_words(input logic [31:0] w[$], input logic [1:0] s[$]);
    wq = w; sq = s;
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; flush = 1'b0; cfg_len = 16'd5;
    cfg_datasize = 2'd0; cfg_msb_first = 1'b0;
    in_data = 32'h12345678; in_valid = 1'b1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_size", 32'(out_datasize), 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_in_ready", in_ready, 0);
    chk("idle_busy", busy, 0);
    in_valid = 1'b0;

    // Byte LSB-first, full rate: 8 units on 8 consecutive cycles.
    set_words('{32'h44332211, 32'h88776655, 32'hCAFEF00D}, '{2'd0, 2'd0, 2'd0});
    run_xfer(8, 1'b0, 100, 100, 9);

    // Half MSB-first, len 3: last half-lane of the second word dropped.
    set_words('{32'hAABBCCDD, 32'h11223344, 32'h55667788}, '{2'd1, 2'd1, 2'd1});
    run_xfer(3, 1'b1, 100, 100, -1);

    // Word mode with a stalling consumer.
    set_words('{32'h0BADCAFE, 32'hFEEDFACE, 32'h01010101}, '{2'd2, 2'd2, 2'd2});
    run_xfer(2, 1'b0, 50, 100, -1);

    // Zero length: nothing accepted, done one cycle later.
    do_start(0, 1'b0);
    in_valid = 1'b1; in_data = 32'h77777777;
    #1;
    chk("len0_done", done, 1);
    chk("len0_ready", in_ready, 0);
    chk("len0_busy", busy, 0);
    @(negedge clk);
    #1;
    chk("len0_done_once", done, 0);
    in_valid = 1'b0;

    // Flush after two bytes of a word.
    do_start(8, 1'b0);
    in_valid = 1'b1; in_data = 32'hDEADBEEF; cfg_datasize = 2'd0; out_ready = 1'b1;
    #1 chk("fl_accept", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("fl_u0", out_data, 32'hEF);
    @(negedge clk);
    #1 chk("fl_u1", out_data, 32'hBE);
    @(negedge clk);
    flush = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("fl_valid", out_valid, 0);
    chk("fl_busy", busy, 0);
    chk("fl_done", done, 0);
    @(negedge clk);
    #1 chk("fl_done2", done, 0);
    set_words('{32'h04030201, 32'h08070605}, '{2'd0, 2'd0});
    run_xfer(4, 1'b0, 100, 100, -1);

    // Size switches from byte to word once the first word is buffered.
    set_words('{32'hA3A2A1A0, 32'hB0B1B2B3, 32'hC0C0C0C0}, '{2'd0, 2'd2, 2'd1});
    run_xfer(5, 1'b0, 70, 100, -1);

    // Randomized transfers.
    for (int t = 0; t < 40; t++) begin
      int len;
      len = $urandom_range(1, 14);
      wq.delete(); sq.delete();
      for (int k = 0; k <= len; k++) begin
        wq.push_back($urandom);
        sq.push_back(2'($urandom_range(0, 3)));
      end
      run_xfer(len, 1'($urandom_range(0, 1)), $urandom_range(30, 100),
               $urandom_range(30, 100), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
